signal_history_trace: RTL and testbench

//  Multi-channel, triggerable circular history buffer for pipeline debug.

---
 rtl/signal_history_trace.sv | 142 ++++++++++++++
 tb/tb_signal_history_trace.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/signal_history_trace.sv
// Multi-channel triggerable circular history buffer with a registered indexed readback port.
// Optional HISTORY_FLAT_OUT_EN adds a combinational flat view of channel 0 (hist_ch0).
module signal_history_trace #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int POST_TRIG = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       arm,
  input  logic                       trig,
  input  logic [CHANNELS*WIDTH-1:0]  sample,
  input  logic [CW-1:0]              rd_ch,
  input  logic [AW-1:0]              rd_idx,
  output logic [WIDTH-1:0]           rd_data,
  output logic [AW:0]                valid_cnt,
  output logic [1:0]                 state,
`ifdef HISTORY_FLAT_OUT_EN
  output logic [0:DEPTH-1][WIDTH-1:0] hist_ch0,
`endif
  output logic                       frozen
);

  typedef enum logic [1:0] {RUN = 2'b00, ARMED = 2'b01, POST = 2'b10, FROZEN = 2'b11} state_e;

  state_e             state_q;
  logic [AW-1:0]      post_cnt_q;
  logic               frozen_q;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]        valid_cnt_q, valid_cnt_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [WIDTH-1:0]   mem_q [CHANNELS][DEPTH];
  logic               capture;
  logic [AW-1:0]      rd_addr;
  logic               rd_hit;

  // flush suppresses the capture of its own cycle's sample
  assign capture = en && (state_q != FROZEN) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      post_cnt_q <= '0;
      frozen_q   <= 1'b0;
    end else if (flush) begin
      state_q    <= RUN;
      post_cnt_q <= '0;
      frozen_q   <= 1'b0;
    end else if (arm) begin
      state_q    <= ARMED;
      post_cnt_q <= '0;
      frozen_q   <= 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (trig && en) begin
            if (POST_TRIG == 0) begin
              state_q  <= FROZEN;
              frozen_q <= 1'b1;
            end else begin
              state_q    <= POST;
              post_cnt_q <= AW'(POST_TRIG);
            end
          end
        end
        POST: begin
          if (en) begin
            post_cnt_q <= post_cnt_q - AW'(1);
            if (post_cnt_q == AW'(1)) begin
              state_q  <= FROZEN;
              frozen_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    valid_cnt_d = valid_cnt_q;
    if (flush) begin
      wr_ptr_d    = '0;
      valid_cnt_d = '0;
    end else if (capture) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (valid_cnt_q != (AW+1)'(DEPTH)) valid_cnt_d = valid_cnt_q + (AW+1)'(1);
    end
  end

  // Readback uses the pre-write pointer/count so a same-cycle write is not visible
  assign rd_addr = wr_ptr_q - AW'(1) - rd_idx;
  assign rd_hit  = ({1'b0, rd_idx} < valid_cnt_q) && (int'(rd_ch) < CHANNELS);

  always_comb begin
    rd_data_d = '0;
    if (rd_hit) rd_data_d = mem_q[rd_ch][rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      valid_cnt_q <= '0;
      rd_data_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      valid_cnt_q <= valid_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < CHANNELS; k++) begin
        mem_q[k][wr_ptr_q] <= sample[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef HISTORY_FLAT_OUT_EN
  always_comb begin
    logic [AW-1:0] age_addr;
    age_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_addr    = wr_ptr_q - AW'(1) - AW'(i);
      hist_ch0[i] = ((AW+1)'(i) < valid_cnt_q) ? mem_q[0][age_addr] : '0;
    end
  end
`endif

  assign rd_data   = rd_data_q;
  assign valid_cnt = valid_cnt_q;
  assign state     = state_q;
  assign frozen    = frozen_q;

endmodule

// File: tb/tb_signal_history_trace.sv
// Scoreboard bench for signal_history_trace: queue-based history model, decoupled monitor.
module tb_signal_history_trace;
  localparam int W = 32, D = 16, CH = 2, P = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, flush, arm, trig;
  logic [CH*W-1:0] sample;
  logic [0:0]    rd_ch;
  logic [3:0]    rd_idx;
  logic [W-1:0]  rd_data;
  logic [4:0]    valid_cnt;
  logic [1:0]    state;
  logic          frozen;

  signal_history_trace #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH), .POST_TRIG(P)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .arm(arm), .trig(trig),
    .sample(sample), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_data(rd_data),
    .valid_cnt(valid_cnt), .state(state), .frozen(frozen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] rd;
    logic [4:0]  vc;
    logic [1:0]  st;
    logic        fr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int step_no = 0;

  // Reference model: newest sample at the front of each queue
  logic [31:0] h0[$];
  logic [31:0] h1[$];
  int m_st = 0;   // 0 RUN, 1 ARMED, 2 POST, 3 FROZEN
  int m_post = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, id, act, exp);
    end
  endtask

  function automatic logic [31:0] mget(input int c, input int idx);
    if (c == 0) return (idx < h0.size()) ? h0[idx] : 32'd0;
    return (idx < h1.size()) ? h1[idx] : 32'd0;
  endfunction

  function automatic void mreset();
    h0.delete();
    h1.delete();
    m_st = 0;
    m_post = 0;
  endfunction

  task automatic step(input logic e, input logic f, input logic a, input logic t,
                      input logic [31:0] s0, input logic [31:0] s1,
                      input logic c, input logic [3:0] idx);
    exp_t x;
    @(negedge clk);
    en = e; flush = f; arm = a; trig = t;
    sample = {s1, s0};
    rd_ch = c; rd_idx = idx;
    step_no++;
    x.id = step_no;
    x.rd = mget(int'(c), int'(idx));
    if (f) begin
      h0.delete(); h1.delete();
      m_st = 0; m_post = 0;
    end else begin
      if (e && m_st != 3) begin
        h0.push_front(s0);
        h1.push_front(s1);
        if (h0.size() > D) void'(h0.pop_back());
        if (h1.size() > D) void'(h1.pop_back());
      end
      if (a) begin
        m_st = 1;
      end else if (m_st == 1 && t && e) begin
        if (P == 0) m_st = 3;
        else begin m_st = 2; m_post = P; end
      end else if (m_st == 2 && e) begin
        m_post--;
        if (m_post == 0) m_st = 3;
      end
    end
    x.vc = 5'(h0.size());
    x.st = 2'(m_st);
    x.fr = (m_st == 3);
    sb.push_back(x);
  endtask

  task automatic cap(input logic [31:0] s0);
    step(1'b1, 1'b0, 1'b0, 1'b0, s0, ~s0, 1'b0, 4'd0);
  endtask

  task automatic rd(input logic c, input logic [3:0] idx);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, c, idx);
  endtask

  // Monitor: every cycle with an outstanding expectation is compared just after the edge
  always @(posedge clk) begin
    #1;
    if (!rst && sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("rd_data",   x.id, rd_data,          x.rd);
      chk("valid_cnt", x.id, 32'(valid_cnt),   32'(x.vc));
      chk("state",     x.id, 32'(state),       32'(x.st));
      chk("frozen",    x.id, 32'(frozen),      32'(x.fr));
    end
  end

  initial begin
    rst = 1'b1; en = 0; flush = 0; arm = 0; trig = 0; sample = '0; rd_ch = 0; rd_idx = 0;
    #12;
    chk("reset_rd_data", 0, rd_data, 32'd0);
    chk("reset_valid",   0, 32'(valid_cnt), 32'd0);
    chk("reset_state",   0, 32'(state), 32'd0);
    chk("reset_frozen",  0, 32'(frozen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mreset();

    // 1: five captures, then reads at ages 0, 4, 5
    for (int i = 1; i <= 5; i++) cap(32'(i));
    rd(1'b0, 4'd0); rd(1'b0, 4'd4); rd(1'b0, 4'd5); rd(1'b1, 4'd0);

    // 2: wrap after 20 captures
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD, 32'hBEEF, 1'b0, 4'd0);
    for (int i = 1; i <= 20; i++) cap(32'(i));
    rd(1'b0, 4'd0); rd(1'b0, 4'd15); rd(1'b1, 4'd15);

    // 3: arm, trigger on 0xA5, freeze after four post samples
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h31, 32'h0, 1'b0, 4'd0);
    cap(32'h32);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hA5, 32'h5A, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) cap(32'h100 + 32'(i));
    rd(1'b0, 4'd4); rd(1'b0, 4'd0); rd(1'b1, 4'd4);

    // 4: re-arm from frozen, stall with a trigger during en=0
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
    rd(1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 32'h77, 1'b0, 4'd0);
    rd(1'b0, 4'd1);

    // 5: flush while POST with nine valid entries
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h201, 32'h0, 1'b0, 4'd0);
    for (int i = 2; i <= 8; i++) cap(32'h200 + 32'(i));
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h209, 32'h0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hF1F1, 32'h0, 1'b0, 4'd0);
    rd(1'b0, 4'd0);

    // 6: arm&trig together stays ARMED; then trigger and reset mid-POST
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h301, 32'h0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h302, 32'h0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h303, 32'h0, 1'b0, 4'd0);
    cap(32'h304);
    rd(1'b0, 4'd0);
    @(posedge clk);
    #3;
    en = 0; flush = 0; arm = 0; trig = 0;
    rst = 1'b1;
    #1;
    chk("arst_rd_data", step_no, rd_data, 32'd0);
    chk("arst_state",   step_no, 32'(state), 32'd0);
    chk("arst_valid",   step_no, 32'(valid_cnt), 32'd0);
    chk("arst_frozen",  step_no, 32'(frozen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mreset();
    rd(1'b0, 4'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(3) != 0), ($urandom_range(39) == 0), ($urandom_range(14) == 0),
           ($urandom_range(5) == 0), $urandom, $urandom, 1'($urandom_range(1)), 4'($urandom_range(15)));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", step_no, 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
